// File: rtl/dct_block_loader.sv
// rtl/dct_block_loader.sv - pixel-to-8x8-block loader with ping-pong banks feeding the 2D-DCT stage
//
// Ports:
//   clock          rising-edge clock for all state
//   reset          asynchronous active-low reset
//   pix_in         8-bit unsigned pixel, raster order within the block
//   pix_valid      pix_in carries a pixel this cycle
//   pix_ready      loader accepts a pixel this cycle (transfer on valid && ready)
//   x_out          64 x 9-bit signed samples of the block being issued
//   in_start       one-cycle start pulse to the DCT
//   dct_done       DCT has consumed the issued block
//   dct_busy       a block is issued and not yet released
//   blocks_issued  wrapping count of in_start pulses

module dct_block_loader (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               pix_in,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    output logic signed [63:0][8:0]  x_out,
    output logic                     in_start,
    input  logic                     dct_done,
    output logic                     dct_busy,
    output logic [15:0]              blocks_issued
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0][63:0][8:0] bank;
    logic [1:0]            full;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [5:0]            wr_idx;

    logic                  accept;
    logic                  fill_done;
    logic                  release_blk;
    logic [1:0]            set_mask;
    logic [1:0]            clr_mask;

    // A bank is refused only while it still holds a block awaiting issue or
    // being consumed; ready depends on registered state only.
    assign pix_ready = !full[wr_bank];
    assign accept    = pix_valid && pix_ready;
    assign fill_done = accept && (wr_idx == 6'd63);

    assign x_out = bank[rd_bank];

    // Set and clear never target the same bank: setting needs the write bank
    // empty, clearing needs the read bank full and in WAIT.
    assign set_mask = fill_done   ? (2'b01 << wr_bank) : 2'b00;
    assign clr_mask = release_blk ? (2'b01 << rd_bank) : 2'b00;

    // Write side: level shift by subtracting 128 in 9-bit arithmetic, which
    // maps 0..255 onto -128..+127 exactly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bank    <= '0;
            wr_bank <= 1'b0;
            wr_idx  <= 6'd0;
        end else if (accept) begin
            bank[wr_bank][wr_idx] <= {1'b0, pix_in} - 9'd128;
            wr_idx                <= wr_idx + 6'd1;
            if (wr_idx == 6'd63) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full <= 2'b00;
        end else begin
            full <= (full | set_mask) & ~clr_mask;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rd_bank       <= 1'b0;
            blocks_issued <= 16'd0;
        end else begin
            state <= state_next;
            if (release_blk) begin
                rd_bank <= ~rd_bank;
            end
            if (state == ISSUE) begin
                blocks_issued <= blocks_issued + 16'd1;
            end
        end
    end

    // Issue FSM. dct_done only matters in WAIT, so a stray pulse while idle
    // or during the start cycle cannot release a block early.
    always_comb begin
        state_next  = state;
        in_start    = 1'b0;
        dct_busy    = 1'b0;
        release_blk = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                in_start   = 1'b1;
                dct_busy   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                dct_busy = 1'b1;
                if (dct_done) begin
                    release_blk = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dct_block_loader.sv
// tb/tb_dct_block_loader.sv - self-checking bench for dct_block_loader

module tb_dct_block_loader;

    logic                    clock;
    logic                    reset;
    logic [7:0]              pix_in;
    logic                    pix_valid;
    logic                    pix_ready;
    logic signed [63:0][8:0] x_out;
    logic                    in_start;
    logic                    dct_done;
    logic                    dct_busy;
    logic [15:0]             blocks_issued;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cnt = 0;

    logic [63:0][8:0] got_q[$];
    int               start_q[$];
    logic [63:0][8:0] hold = '0;
    logic             prev_start = 1'b0;
    int               stab_err = 0;
    int               dbl_err  = 0;

    dct_block_loader dut (
        .clock         (clock),
        .reset         (reset),
        .pix_in        (pix_in),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .x_out         (x_out),
        .in_start      (in_start),
        .dct_done      (dct_done),
        .dct_busy      (dct_busy),
        .blocks_issued (blocks_issued)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every issued block with the cycle it appeared, and watch that the
    // presented block never changes while the DCT owns it.
    always @(negedge clock) begin
        if (in_start) begin
            got_q.push_back(x_out);
            start_q.push_back(cyc);
            hold <= x_out;
        end else if (dct_busy && (x_out !== hold)) begin
            stab_err <= stab_err + 1;
        end
        if (in_start && prev_start) dbl_err <= dbl_err + 1;
        prev_start <= in_start;
    end

    // Reference: each sample is the pixel minus 128 as a 9-bit two's complement value.
    function automatic logic [63:0][8:0] exp_block(input logic [7:0] v[64]);
        logic [63:0][8:0] b;
        for (int i = 0; i < 64; i++) b[i] = 9'(int'(v[i]) - 128);
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        pix_valid = 1'b0;
        dct_done = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Drive n pixels; bubble 0 = back-to-back, 1 = alternate, 2 = random valid.
    // e_cyc is the clock edge that captures the last pixel.
    task automatic send_pixels(input logic [7:0] v[64], input int n, input int bubble, output int e_cyc);
        int k = 0;
        int t = 0;
        int ph = 0;
        e_cyc = 0;
        while (k < n && t < 4000) begin
            @(negedge clock);
            if ((bubble == 1 && ph == 1) || (bubble == 2 && $urandom_range(0, 1) == 0)) begin
                pix_valid = 1'b0;
            end else begin
                pix_valid = 1'b1;
                pix_in = v[k];
            end
            ph = 1 - ph;
            t++;
            if (pix_valid && pix_ready) begin
                k++;
                acc_cnt++;
                e_cyc = cyc + 1;
            end
        end
        @(posedge clock);
        #1 pix_valid = 1'b0;
        n_cmp++;
        if (k !== n) begin
            n_fail++;
            $display("FAIL send_timeout: sent %0d pixels, required %0d", k, n);
        end
    endtask

    // DCT model: wait for in_start, then pulse dct_done after delay cycles.
    // d_cyc is the edge that samples dct_done.
    task automatic dct_serve(input int delay, output int d_cyc);
        int t = 0;
        d_cyc = 0;
        @(negedge clock);
        while (!in_start && t < 3000) begin
            @(negedge clock);
            t++;
        end
        n_cmp++;
        if (in_start !== 1'b1) begin
            n_fail++;
            $display("FAIL serve_timeout: in_start=%b, required 1", in_start);
        end else begin
            repeat (delay - 1) @(negedge clock);
            dct_done = 1'b1;
            d_cyc = cyc + 1;
            @(negedge clock);
            dct_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_cmp++; if (x_out !== '0) begin n_fail++; $display("FAIL reset_x_out: got %h, required 0", x_out); end
        n_cmp++; if (in_start !== 1'b0) begin n_fail++; $display("FAIL reset_in_start: got %b, required 0", in_start); end
        n_cmp++; if (dct_busy !== 1'b0) begin n_fail++; $display("FAIL reset_dct_busy: got %b, required 0", dct_busy); end
        n_cmp++; if (blocks_issued !== 16'd0) begin n_fail++; $display("FAIL reset_blocks: got %0d, required 0", blocks_issued); end
        n_cmp++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pix_ready: got %b, required 1", pix_ready); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_ramp();
        logic [7:0] v[64];
        logic [63:0][8:0] exp;
        int e, d, base;
        do_reset();
        base = got_q.size();
        for (int i = 0; i < 64; i++) v[i] = 8'(i);
        exp = exp_block(v);
        fork
            send_pixels(v, 64, 0, e);
            dct_serve(10, d);
        join
        repeat (3) @(negedge clock);
        n_cmp++; if (got_q.size() - base !== 1) begin n_fail++; $display("FAIL ramp_starts: got %0d, required 1", got_q.size() - base); end
        if (got_q.size() > base) begin
            n_cmp++; if (got_q[base][0] !== 9'h180) begin n_fail++; $display("FAIL ramp_x0: got %h, required 180", got_q[base][0]); end
            n_cmp++; if (got_q[base][63] !== 9'h1BF) begin n_fail++; $display("FAIL ramp_x63: got %h, required 1bf", got_q[base][63]); end
            n_cmp++; if (got_q[base] !== exp) begin n_fail++; $display("FAIL ramp_block: got %h, required %h", got_q[base], exp); end
            n_cmp++; if (start_q[base] !== e + 1) begin n_fail++; $display("FAIL ramp_latency: start at %0d, required %0d", start_q[base], e + 1); end
        end
        n_cmp++; if (blocks_issued !== 16'd1) begin n_fail++; $display("FAIL ramp_count: got %0d, required 1", blocks_issued); end
        n_cmp++; if (dct_busy !== 1'b0) begin n_fail++; $display("FAIL ramp_busy: got %b, required 0", dct_busy); end
        n_cmp++; if (dbl_err !== 0) begin n_fail++; $display("FAIL ramp_pulse_width: got %0d double pulses, required 0", dbl_err); end
    endtask

    task automatic test_extremes();
        logic [7:0] v1[64];
        logic [7:0] v2[64];
        int e1, e2, d1, d2, base, exp_s;
        do_reset();
        base = got_q.size();
        for (int i = 0; i < 64; i++) begin v1[i] = 8'd255; v2[i] = 8'd128; end
        fork
            begin send_pixels(v1, 64, 0, e1); send_pixels(v2, 64, 0, e2); end
            begin dct_serve(5, d1); dct_serve(5, d2); end
        join
        repeat (3) @(negedge clock);
        exp_s = (e2 > d1) ? e2 + 1 : d1 + 1;
        n_cmp++; if (got_q.size() - base !== 2) begin n_fail++; $display("FAIL ext_starts: got %0d, required 2", got_q.size() - base); end
        if (got_q.size() - base >= 2) begin
            n_cmp++; if (got_q[base] !== {64{9'h07F}}) begin n_fail++; $display("FAIL ext_255: got %h, required all 07f", got_q[base]); end
            n_cmp++; if (got_q[base + 1] !== exp_block(v2)) begin n_fail++; $display("FAIL ext_128: got %h, required all 0", got_q[base + 1]); end
            n_cmp++; if (start_q[base + 1] !== exp_s) begin n_fail++; $display("FAIL ext_second_start: at %0d, required %0d (done %0d)", start_q[base + 1], exp_s, d1); end
        end
        n_cmp++; if (blocks_issued !== 16'd2) begin n_fail++; $display("FAIL ext_count: got %0d, required 2", blocks_issued); end
    endtask

    task automatic test_backpressure();
        logic [7:0] v1[64];
        logic [7:0] v2[64];
        logic [7:0] v3[64];
        int e, d, base, acc0, t;
        do_reset();
        base = got_q.size();
        acc0 = acc_cnt;
        for (int i = 0; i < 64; i++) begin v1[i] = 8'($urandom); v2[i] = 8'($urandom); v3[i] = 8'd200; end
        fork
            begin send_pixels(v1, 64, 0, e); send_pixels(v2, 64, 0, e); send_pixels(v3, 64, 0, e); end
            begin
                t = 0;
                while (acc_cnt - acc0 < 128 && t < 1000) begin @(negedge clock); t++; end
                repeat (20) @(negedge clock);
                n_cmp++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b, required 0", pix_ready); end
                n_cmp++; if (acc_cnt - acc0 !== 128) begin n_fail++; $display("FAIL bp_accepted: got %0d, required 128", acc_cnt - acc0); end
                n_cmp++; if (blocks_issued !== 16'd1) begin n_fail++; $display("FAIL bp_count_held: got %0d, required 1", blocks_issued); end
                dct_done = 1'b1;
                @(negedge clock);
                dct_done = 1'b0;
                n_cmp++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise: got %b, required 1", pix_ready); end
                dct_serve(3, d);
                dct_serve(3, d);
            end
        join
        repeat (3) @(negedge clock);
        n_cmp++; if (got_q.size() - base !== 3) begin n_fail++; $display("FAIL bp_starts: got %0d, required 3", got_q.size() - base); end
        if (got_q.size() - base >= 3) begin
            n_cmp++; if (got_q[base] !== exp_block(v1)) begin n_fail++; $display("FAIL bp_block1: got %h, required %h", got_q[base], exp_block(v1)); end
            n_cmp++; if (got_q[base + 1] !== exp_block(v2)) begin n_fail++; $display("FAIL bp_block2: got %h, required %h", got_q[base + 1], exp_block(v2)); end
            n_cmp++; if (got_q[base + 2] !== {64{9'h048}}) begin n_fail++; $display("FAIL bp_block3: got %h, required all 048", got_q[base + 2]); end
        end
        n_cmp++; if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes, required 0", stab_err); end
    endtask

    task automatic test_bubbles();
        logic [7:0] v[64];
        int e, d, base;
        do_reset();
        base = got_q.size();
        for (int i = 0; i < 64; i++) v[i] = 8'd7;
        fork
            send_pixels(v, 64, 1, e);
            dct_serve(4, d);
        join
        repeat (3) @(negedge clock);
        n_cmp++; if (got_q.size() - base !== 1) begin n_fail++; $display("FAIL bub_starts: got %0d, required 1", got_q.size() - base); end
        if (got_q.size() > base) begin
            n_cmp++; if (got_q[base] !== {64{9'h187}}) begin n_fail++; $display("FAIL bub_block: got %h, required all 187", got_q[base]); end
            n_cmp++; if (start_q[base] !== e + 1) begin n_fail++; $display("FAIL bub_latency: start at %0d, required %0d", start_q[base], e + 1); end
        end
    endtask

    task automatic test_coincidence();
        logic [7:0] va[64];
        logic [7:0] vb[64];
        int ea, eb, s, dd, d2, t, base;
        do_reset();
        base = got_q.size();
        dd = 0;
        for (int i = 0; i < 64; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
        fork
            begin send_pixels(va, 64, 0, ea); send_pixels(vb, 64, 0, eb); end
            begin
                t = 0;
                @(negedge clock);
                while (!in_start && t < 500) begin @(negedge clock); t++; end
                s = cyc;
                while (cyc < s + 62) @(negedge clock);
                dct_done = 1'b1;
                dd = cyc + 1;
                @(negedge clock);
                dct_done = 1'b0;
                dct_serve(2, d2);
            end
        join
        repeat (3) @(negedge clock);
        n_cmp++; if (eb !== dd) begin n_fail++; $display("FAIL coin_align: last pixel edge %0d, done edge %0d", eb, dd); end
        n_cmp++; if (got_q.size() - base !== 2) begin n_fail++; $display("FAIL coin_starts: got %0d, required 2", got_q.size() - base); end
        if (got_q.size() - base >= 2) begin
            n_cmp++; if (start_q[base + 1] !== dd + 1) begin n_fail++; $display("FAIL coin_start: at %0d, required %0d", start_q[base + 1], dd + 1); end
            n_cmp++; if (got_q[base + 1] !== exp_block(vb)) begin n_fail++; $display("FAIL coin_block: got %h, required %h", got_q[base + 1], exp_block(vb)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v[64];
        logic [7:0] r[64];
        int e, d, base, t;
        do_reset();
        for (int i = 0; i < 64; i++) begin v[i] = 8'(i); r[i] = 8'($urandom); end
        send_pixels(v, 29, 0, e);
        @(negedge clock);
        pix_valid = 1'b1;
        pix_in = 8'd29;
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (x_out !== '0) begin n_fail++; $display("FAIL rst_pix_x_out: got %h, required 0", x_out); end
        n_cmp++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pix_ready: got %b, required 1", pix_ready); end
        pix_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        send_pixels(r, 64, 0, e);
        t = 0;
        while (!(dct_busy && !in_start) && t < 50) begin @(negedge clock); t++; end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (x_out !== '0) begin n_fail++; $display("FAIL rst_wait_x_out: got %h, required 0", x_out); end
        n_cmp++; if (dct_busy !== 1'b0) begin n_fail++; $display("FAIL rst_wait_busy: got %b, required 0", dct_busy); end
        n_cmp++; if (in_start !== 1'b0) begin n_fail++; $display("FAIL rst_wait_start: got %b, required 0", in_start); end
        n_cmp++; if (blocks_issued !== 16'd0) begin n_fail++; $display("FAIL rst_wait_count: got %0d, required 0", blocks_issued); end
        @(negedge clock);
        reset = 1'b1;
        base = got_q.size();
        repeat (10) @(negedge clock);
        n_cmp++; if (got_q.size() !== base) begin n_fail++; $display("FAIL rst_spurious: got %0d starts, required 0", got_q.size() - base); end
        fork
            send_pixels(v, 64, 0, e);
            dct_serve(6, d);
        join
        repeat (3) @(negedge clock);
        n_cmp++; if (got_q.size() - base !== 1) begin n_fail++; $display("FAIL rst_fresh_starts: got %0d, required 1", got_q.size() - base); end
        if (got_q.size() > base) begin
            n_cmp++; if (got_q[base] !== exp_block(v)) begin n_fail++; $display("FAIL rst_fresh_block: got %h, required %h", got_q[base], exp_block(v)); end
        end
        n_cmp++; if (blocks_issued !== 16'd1) begin n_fail++; $display("FAIL rst_fresh_count: got %0d, required 1", blocks_issued); end
    endtask

    task automatic test_random();
        logic [7:0] v[4][64];
        logic [7:0] cur[64];
        int e, d, base;
        do_reset();
        base = got_q.size();
        for (int b = 0; b < 4; b++) for (int i = 0; i < 64; i++) v[b][i] = 8'($urandom);
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    for (int i = 0; i < 64; i++) cur[i] = v[b][i];
                    send_pixels(cur, 64, 2, e);
                end
            end
            begin
                for (int b = 0; b < 4; b++) dct_serve($urandom_range(1, 150), d);
            end
        join
        repeat (3) @(negedge clock);
        n_cmp++; if (got_q.size() - base !== 4) begin n_fail++; $display("FAIL rnd_starts: got %0d, required 4", got_q.size() - base); end
        if (got_q.size() - base >= 4) begin
            for (int b = 0; b < 4; b++) begin
                logic [7:0] w[64];
                for (int i = 0; i < 64; i++) w[i] = v[b][i];
                n_cmp++;
                if (got_q[base + b] !== exp_block(w)) begin
                    n_fail++;
                    $display("FAIL rnd_block%0d: got %h, required %h", b, got_q[base + b], exp_block(w));
                end
            end
        end
        n_cmp++; if (blocks_issued !== 16'd4) begin n_fail++; $display("FAIL rnd_count: got %0d, required 4", blocks_issued); end
        n_cmp++; if (stab_err !== 0) begin n_fail++; $display("FAIL rnd_stable: got %0d changes, required 0", stab_err); end
        n_cmp++; if (dbl_err !== 0) begin n_fail++; $display("FAIL rnd_pulse_width: got %0d double pulses, required 0", dbl_err); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        pix_in = 8'd0;
        pix_valid = 1'b0;
        dct_done = 1'b0;
        test_reset();
        test_ramp();
        test_extremes();
        test_backpressure();
        test_bubbles();
        test_coincidence();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dct_block_loader.md
# dct_block_loader

Upstream feeder for the 2D-DCT stage. It accepts a raster-order stream of 8-bit unsigned pixels and level-shifts each one to 9-bit signed (pixel − 128). It assembles the pixels into 8×8 blocks in a two-bank ping-pong buffer and hands each full block to the DCT stage with a one-cycle start pulse. Each block is held stable on the DCT input bus until the DCT reports its output transfer.

## Interface
Parameters:
- none (block size fixed at 64 samples, 8-bit in, 9-bit out)

Ports:
- clock  in  1  single clock; all state on its rising edge
- reset  in  1  asynchronous, active-low reset
- pix_in  in  8  unsigned pixel, raster order within the 8×8 block (index = row*8 + col)
- pix_valid  in  1  pix_in is valid this cycle
- pix_ready  out  1  loader can accept a pixel; transfer occurs when pix_valid && pix_ready at a clock edge
- x_out  out  64×9 (packed [63:0][8:0], signed)  block presented to DCT x input; element i = sample i
- in_start  out  1  one-cycle pulse to DCT IN_START; x_out is valid from this cycle on
- dct_done  in  1  DCT OUT_XFC; high for one cycle when the DCT has consumed the block
- dct_busy  out  1  a block has been issued and dct_done has not yet been seen
- blocks_issued  out  16  count of in_start pulses, wraps 0xFFFF→0

## Operation
- Storage: bank[0], bank[1], each 64×9 bit registers, plus full[1:0] flags.
- Write side: wr_bank (1 bit), wr_idx (6 bit). On each accepted pixel:
  - write bank[wr_bank][wr_idx] ← {1'b0,pix_in} − 9'd128, so the result range is −128..+127 with no saturation;
  - increment wr_idx;
  - on wr_idx==63: set full[wr_bank], toggle wr_bank, wrap wr_idx to 0.
- pix_ready = !full[wr_bank]. It is low only when the bank being written is still awaiting issue or is being consumed.
- Read side: rd_bank (1 bit). x_out = bank[rd_bank], fully combinational mux of register contents.
- Issue FSM with states IDLE, ISSUE, WAIT:
  - IDLE: if full[rd_bank], go to ISSUE.
  - ISSUE (one cycle): in_start=1, dct_busy=1, blocks_issued++. Next state is WAIT.
  - WAIT: dct_busy=1. On dct_done: clear full[rd_bank], toggle rd_bank, go to IDLE.
- dct_done in IDLE or ISSUE is ignored.
- Bank contents are never written while the bank's full flag is set, so x_out is stable from in_start until dct_done.

## Timing
- Reset (asserted low) values:
  - banks all 0, full=00, wr_bank=rd_bank=0, wr_idx=0;
  - FSM=IDLE;
  - in_start=0, dct_busy=0, blocks_issued=0, x_out=0, pix_ready=1.
- Throughput: one pixel per cycle while pix_ready=1. pix_valid may drop at any time; wr_idx holds.
- Latency: 64th pixel captured at edge E → full set at E → FSM enters ISSUE at E+1. in_start is high for the cycle E+1..E+2.
- in_start is exactly one cycle wide. It is never reasserted before dct_done has been seen for the prior block.
- Release: dct_done sampled at edge D clears full and toggles rd_bank at D. If the other bank is already full, the next in_start is at D+1 (IDLE for one cycle, then ISSUE).
- Same-edge events:
  - dct_done at the edge that writes the 64th pixel of the other bank: both flags update at that edge, and the next issue follows at +1.
  - If full[wr_bank] clears at the same edge as a pixel arrives with pix_ready=0, that pixel is not taken. pix_ready rises the following cycle.
- Both banks full: pix_ready=0 until the next dct_done. No pixel is dropped or overwritten.
- Reset mid-block or mid-WAIT: all state is discarded immediately (asynchronous). The partial block is lost, in_start and dct_busy drop at once, and no spurious in_start follows reset release.

## Test plan
- Ramp: pixels 0..63 back-to-back, DCT model returns dct_done 10 cycles after in_start → single in_start at E+1. Required x_out values: x_out[0]=−128 (9'h180), x_out[63]=−65 (9'h1BF), x_out[i]=i−128. Also blocks_issued=1.
- Extremes: block of all 255 then block of all 128 → x_out all +127 (9'h07F), then all 0. Second in_start only after the first dct_done.
- Backpressure: stream 192 pixels continuously with dct_done withheld → pix_ready falls after pixel 128 and stays low. Release dct_done → pix_ready rises. The third block (values 200) is issued intact.
- Bubbles: pix_valid toggled 1/0 on alternate cycles over 64 pixels (value 7) → one in_start. All 64 x_out entries are −121.
- Coincidence: dct_done asserted on the same edge as the 64th pixel of bank 1 → rd_bank toggles and in_start follows one cycle later, carrying bank 1 data.
- Reset mid-operation: reset pulsed low during pixel 30 and again during WAIT. Outputs zero immediately, pix_ready=1. Then a fresh 64-pixel ramp yields exactly one in_start and blocks_issued=1.
